stochastic_addmultiply: RTL and testbench
=========================================

Name: stochastic_addmultiply

Overview:
- Tiny Tapeout user tile that does stochastic-computing arithmetic on two 7-bit unipolar operands A and B (value = operand/128).
- Each operand is turned into a random bitstream by comparing it with LFSR-derived random numbers.
- Mode 0 multiplies (AND of the streams); mode 1 is a scaled add (MUX of the streams, select probability 0.5).
- Ones are counted over a 128-cycle frame and the count is presented on uo_out. The block is the top of the tile.

Parameters:
- FRAME_LOG2, 7, log2 of the frame length in clocks; operand width equals FRAME_LOG2.
- LFSR_SEED, 16'hACE1, LFSR reset value; must be nonzero.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- ena  input  1  tile enable; when 0, all state holds.
- ui_in  input  8  [6:0] = operand A; [7] = mode (0 multiply, 1 scaled add).
- uio_in  input  8  [6:0] = operand B; [7] unused.
- uo_out  output  8  latched ones-count of the last completed frame, range 0..128.
- uio_out  output  8  constant 8'h00.
- uio_oe  output  8  constant 8'h00 (all bidirectional pins are inputs).

Behaviour:
- Reset (async, rst_n=0):
  - lfsr = LFSR_SEED, frame counter = 0, accumulator = 0, uo_out = 0.
  - uio_out = 0 and uio_oe = 0 at all times.
- LFSR: 16-bit Fibonacci, shifts left every enabled clock.
  - lfsr <= {lfsr[14:0], lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]}.
  - Period 65535; it never reaches 0.
- Per enabled cycle, from the current (pre-shift) lfsr:
  - RA = lfsr[6:0]; RB = lfsr[13:7]; S = lfsr[15].
  - a = (RA < A); b = (RB < B). Compares are unsigned 7-bit.
  - Mode 0: bit = a & b. Mode 1: bit = S ? b : a.
- Operands and mode are read live every cycle. Changing them mid-frame gives a mixed result; this is legal and not an error.
- Accumulator: 8-bit, increments by bit every enabled cycle. Maximum value 128, so it never wraps.
- Frame counter: 7-bit, increments every enabled cycle.
  - On the cycle where the counter is 127, uo_out <= accumulator + bit (the full 128-cycle count).
  - The accumulator is cleared to 0 on that same edge; the counter wraps to 0.
- Latency: first valid uo_out appears on the 128th enabled rising edge after reset release. It then updates every 128 enabled cycles and holds in between.
- Expected value:
  - Mode 0: uo_out ≈ A*B/128.
  - Mode 1: uo_out ≈ (A+B)/2.
  - A=0 forces a=0 exactly; B=0 forces b=0 exactly.
- ena=0: LFSR, counter, accumulator and uo_out all hold. Resuming continues the frame seamlessly.
- Reset mid-frame: partial accumulation is discarded and uo_out returns to 0 immediately.
- The result is deterministic for a given seed and input history, so a bit-exact software model is possible.

Decomposition:
- Shared package holds: FRAME_LOG2, LFSR_SEED, the LFSR tap constants, and the mode encodings MODE_MUL=0 and MODE_ADD=1.
- One sub-module, stoch_sng (stochastic number generator): random word plus operand in, comparator bit out; instantiated twice.
- LFSR, combiner, accumulator and frame counter stay in the top.

Test Plan:
- Reset, then check uo_out/uio_out/uio_oe: rst_n low at any time -> 8'h00 / 8'h00 / 8'h00; uo_out stays 0 for the first 127 enabled cycles.
- Multiply zero: A=0, B=127, mode=0, run 3 frames -> every latched uo_out = 0. Repeat with A=127, B=0 -> 0.
- Multiply full scale: A=127, B=127, mode=0 -> uo_out within 126±12. A=64, B=64 -> 32±10. Must match the bit-exact model.
- Scaled add: mode=1; A=0, B=0 -> 0 exactly. A=127, B=0 -> 64±12. A=64, B=64 -> 64±10. All bit-exact against the model.
- Enable gating: drop ena for 50 cycles mid-frame -> uo_out and the frame phase are unchanged; the next result equals the model with those cycles removed.
- Reset mid-frame: assert rst_n low at cycle 60 of a frame -> uo_out=0 at once; next update 128 enabled cycles after release, with the LFSR restarted from the seed.

Source files
------------

// File: rtl/stochastic_addmultiply_pkg.sv
// Shared constants for the stochastic add/multiply tile: frame size, LFSR seed/taps, mode encodings.
package stochastic_addmultiply_pkg;

  localparam int unsigned FRAME_LOG2 = 7;
  localparam int unsigned LFSR_W     = 16;
  localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;

  // Feedback taps at bits 15, 13, 12, 10 (maximal-length, period 65535)
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  typedef enum logic {
    MODE_MUL = 1'b0,
    MODE_ADD = 1'b1
  } mode_e;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/stochastic_addmultiply_sng.sv
// Stochastic number generator: emits 1 when the random word is below the operand.
module stoch_sng #(
  parameter int unsigned W = 7
) (
  input  logic [W-1:0] rnd,
  input  logic [W-1:0] operand,
  output logic         stream_c
);

  assign stream_c = (rnd < operand);

endmodule

// File: rtl/stochastic_addmultiply.sv
// Stochastic-computing tile: AND (multiply) or MUX (scaled add) of two bitstreams,
// ones counted over a 2**FRAME_LOG2 cycle frame and latched onto uo_out.
module stochastic_addmultiply
  import stochastic_addmultiply_pkg::*;
#(
  parameter int unsigned       FRAME_LOG2_P = FRAME_LOG2,
  parameter logic [LFSR_W-1:0] LFSR_SEED_P  = LFSR_SEED
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int unsigned W     = FRAME_LOG2_P;
  localparam int unsigned ACC_W = FRAME_LOG2_P + 1;

  logic [LFSR_W-1:0] lfsr;
  logic [W-1:0]      frame_cnt;
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  acc_sum_c;
  logic              a_c;
  logic              b_c;
  logic              sel_c;
  logic              sample_c;
  logic              frame_end_c;
  mode_e             mode_c;
  logic              unused_c;

  assign uio_out  = 8'h00;
  assign uio_oe   = 8'h00;
  assign unused_c = ^{uio_in[7], ui_in[7:0], uio_in[6:0]};

  assign mode_c = mode_e'(ui_in[7]);
  assign sel_c  = lfsr[LFSR_W-1];

  stoch_sng #(.W(W)) u_sng_a (
    .rnd      (lfsr[W-1:0]),
    .operand  (ui_in[W-1:0]),
    .stream_c (a_c)
  );

  stoch_sng #(.W(W)) u_sng_b (
    .rnd      (lfsr[2*W-1:W]),
    .operand  (uio_in[W-1:0]),
    .stream_c (b_c)
  );

  // Combine the two streams according to the live mode bit
  always_comb begin
    sample_c = 1'b0;
    case (mode_c)
      MODE_MUL: sample_c = a_c & b_c;
      MODE_ADD: sample_c = sel_c ? b_c : a_c;
      default:  sample_c = 1'b0;
    endcase
  end

  assign frame_end_c = (frame_cnt == {W{1'b1}});
  assign acc_sum_c   = acc + ACC_W'(sample_c);

  // LFSR, frame counter, accumulator and result latch; everything freezes when ena=0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr      <= LFSR_SEED_P;
      frame_cnt <= '0;
      acc       <= '0;
      uo_out    <= 8'h00;
    end else if (ena) begin
      lfsr      <= lfsr_next(lfsr);
      frame_cnt <= frame_cnt + W'(1);
      if (frame_end_c) begin
        uo_out <= 8'(acc_sum_c);
        acc    <= '0;
      end else begin
        acc    <= acc_sum_c;
      end
    end
  end

endmodule

// File: tb/tb_stochastic_addmultiply.sv
// Directed bench for stochastic_addmultiply with a cycle-exact reference model.
module tb_stochastic_addmultiply;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] m_lfsr;
  int          m_cnt;
  int          m_acc;
  int          m_out;

  stochastic_addmultiply dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;

  task automatic expect_eq(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_lfsr = 16'hACE1;
    m_cnt  = 0;
    m_acc  = 0;
    m_out  = 0;
  endtask

  // Advance the model with the inputs currently applied, then step past one rising edge
  task automatic tick();
    int ra, rb, opa, opb;
    bit sa, sb, s, bt;
    if (ena) begin
      ra  = int'(m_lfsr[6:0]);
      rb  = int'(m_lfsr[13:7]);
      s   = m_lfsr[15];
      opa = int'(ui_in[6:0]);
      opb = int'(uio_in[6:0]);
      sa  = (ra < opa);
      sb  = (rb < opb);
      bt  = ui_in[7] ? (s ? sb : sa) : (sa & sb);
      if (m_cnt == 127) begin
        m_out = m_acc + int'(bt);
        m_acc = 0;
        m_cnt = 0;
      end else begin
        m_acc = m_acc + int'(bt);
        m_cnt = m_cnt + 1;
      end
      m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input int a, input int b, input bit mode);
    ui_in  = {mode, 7'(a)};
    uio_in = {1'b0, 7'(b)};
  endtask

  task automatic run_frames(input string tag, input int n, output int sum);
    sum = 0;
    for (int f = 0; f < n; f++) begin
      repeat (128) tick();
      expect_eq(tag, int'(uo_out), m_out);
      sum = sum + int'(uo_out);
    end
  endtask

  task automatic expect_range(input string tag, input int sum, input int lo, input int hi);
    if (sum < lo || sum > hi)
      $display("  %s: 3-frame sum %0d outside [%0d,%0d]", tag, sum, lo, hi);
    expect_eq(tag, int'(sum >= lo && sum <= hi), 1);
  endtask

  initial begin
    int s;
    int hold;

    model_reset();
    set_in(0, 127, 1'b0);
    ena = 1'b1;
    #2;
    expect_eq("rst_uo_out", int'(uo_out), 0);
    expect_eq("rst_uio_out", int'(uio_out), 0);
    expect_eq("rst_uio_oe", int'(uio_oe), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // No result may appear before the 128th enabled edge
    for (int i = 0; i < 127; i++) begin
      tick();
      expect_eq("early_uo_zero", int'(uo_out), 0);
    end
    tick();
    expect_eq("mul_a0_first", int'(uo_out), m_out);
    expect_eq("mul_a0_first_zero", int'(uo_out), 0);

    run_frames("mul_a0_model", 2, s);
    expect_eq("mul_a0_zero", s, 0);

    set_in(127, 0, 1'b0);
    run_frames("mul_b0_model", 3, s);
    expect_eq("mul_b0_zero", s, 0);

    set_in(127, 127, 1'b0);
    run_frames("mul_full_model", 3, s);
    expect_range("mul_full_range", s, 3 * 114, 3 * 138);

    set_in(64, 64, 1'b0);
    run_frames("mul_half_model", 3, s);
    expect_range("mul_half_range", s, 3 * 22, 3 * 42);

    set_in(0, 0, 1'b1);
    run_frames("add_zero_model", 3, s);
    expect_eq("add_zero_exact", s, 0);

    set_in(127, 0, 1'b1);
    run_frames("add_a_model", 3, s);
    expect_range("add_a_range", s, 3 * 52, 3 * 76);

    set_in(64, 64, 1'b1);
    run_frames("add_half_model", 3, s);
    expect_range("add_half_range", s, 3 * 54, 3 * 74);

    expect_eq("run_uio_out", int'(uio_out), 0);
    expect_eq("run_uio_oe", int'(uio_oe), 0);

    // Enable gating: 50 frozen cycles inside a frame must not shift the frame phase
    set_in(100, 80, 1'b0);
    repeat (60) tick();
    hold = int'(uo_out);
    ena = 1'b0;
    repeat (50) tick();
    expect_eq("ena_hold_uo", int'(uo_out), hold);
    ena = 1'b1;
    repeat (67) tick();
    expect_eq("ena_phase_hold", int'(uo_out), hold);
    tick();
    expect_eq("ena_resume_model", int'(uo_out), m_out);

    // Reset at cycle 60 of a frame: output clears at once, LFSR restarts from the seed
    set_in(64, 64, 1'b0);
    repeat (60) tick();
    #2;
    rst_n = 1'b0;
    #1;
    expect_eq("midrst_uo_zero", int'(uo_out), 0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (127) tick();
    expect_eq("midrst_early_zero", int'(uo_out), 0);
    tick();
    expect_eq("midrst_frame_model", int'(uo_out), m_out);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
